// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, status bit layout
// and the default MMIO locations of the UART registers.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;

    localparam logic [31:0] UART_IO_MM_LOC  = 32'h0000_0054;
    localparam logic [31:0] DEF_RX_DATA_LOC = 32'h0000_0058;
    localparam logic [31:0] DEF_STATUS_LOC  = 32'h0000_005C;

    function automatic logic [31:0] status_word(input logic frame_err,
                                                input logic overrun,
                                                input logic not_empty);
        logic [31:0] w;
        w               = '0;
        w[ST_NOT_EMPTY] = not_empty;
        w[ST_OVERRUN]   = overrun;
        w[ST_FRAME_ERR] = frame_err;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 serial deserializer: two-flop input synchronizer plus an
// IDLE/START/DATA/STOP sampling FSM; state is exported for observation.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output rx_state_e  state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t HALF = cnt_t'(CLKS_PER_BIT / 2 - 1);
    localparam cnt_t LAST = cnt_t'(CLKS_PER_BIT - 1);

    logic       rx_meta;
    logic       rx_s;
    cnt_t       cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       stop_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Mid start bit: a high line here means the low pulse was a glitch.
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        state <= RX_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // Pulses are decoded from the registered FSM so the FIFO captures the byte
    // on the stop-bit sample edge itself, making it visible one cycle later.
    assign stop_edge       = (state == RX_STOP) && (cnt == LAST);
    assign byte_valid      = stop_edge && rx_s;
    assign frame_err_pulse = stop_edge && !rx_s;
    assign rx_byte         = shift;

endmodule

// File: rtl/uart_rx_mmio.sv
// UART receive block: deserializer, receive FIFO with sticky overrun/frame
// flags, and the memory-mapped RX data / status read port.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] RX_DATA_LOC  = DEF_RX_DATA_LOC,
    parameter logic [31:0] STATUS_LOC   = DEF_STATUS_LOC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_uart_rx,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_rd,
    input  logic        ip_data_wr,
    output logic        op_data_valid,
    output logic [31:0] op_data_from_dev,
    output logic        op_rx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    rx_byte;
    logic          rx_push;
    logic          fe_pulse;
    rx_state_e     rx_state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;

    logic          rx_sel;
    logic          st_sel;
    logic          not_empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;
    logic          clr_flags;

    uart_rx_deser #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_deser (
        .clk            (clk),
        .reset          (reset),
        .rx             (ip_uart_rx),
        .rx_byte        (rx_byte),
        .byte_valid     (rx_push),
        .frame_err_pulse(fe_pulse),
        .state          (rx_state)
    );

    assign rx_sel    = (ip_data_addr == RX_DATA_LOC);
    assign st_sel    = (ip_data_addr == STATUS_LOC);
    assign not_empty = (count != '0);
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign do_pop    = ip_data_rd && rx_sel && not_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push   = rx_push && (!full || do_pop);
    assign drop      = rx_push && !do_push;
    assign clr_flags = ip_data_wr && st_sel;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // Set events take priority over a software clear in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (fe_pulse) begin
                frame_err <= 1'b1;
            end else if (clr_flags) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_comb begin
        op_data_valid    = 1'b0;
        op_data_from_dev = '0;
        if (rx_sel) begin
            op_data_valid    = 1'b1;
            op_data_from_dev = not_empty ? {24'b0, mem[rd_ptr]} : 32'h0;
        end else if (st_sel) begin
            op_data_valid    = 1'b1;
            op_data_from_dev = status_word(frame_err, overrun, not_empty);
        end
    end

    assign op_rx_irq = not_empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: serial frame driver, MMIO bus task,
// expected-byte queue, a decode vector table and multi-cycle corner sequences.
module tb_uart_rx_mmio;
    import uart_pkg::*;

    localparam int          CPB   = 16;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RX_A  = 32'h0000_0058;
    localparam logic [31:0] ST_A  = 32'h0000_005C;

    logic        clk;
    logic        reset;
    logic        ip_uart_rx;
    logic [31:0] ip_data_addr;
    logic        ip_data_rd;
    logic        ip_data_wr;
    logic        op_data_valid;
    logic [31:0] op_data_from_dev;
    logic        op_rx_irq;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[10];

    uart_rx_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ip_uart_rx      (ip_uart_rx),
        .ip_data_addr    (ip_data_addr),
        .ip_data_rd      (ip_data_rd),
        .ip_data_wr      (ip_data_wr),
        .op_data_valid   (op_data_valid),
        .op_data_from_dev(op_data_from_dev),
        .op_rx_irq       (op_rx_irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // driver tasks
    task automatic bus(input logic [31:0] addr, input logic rd, input logic wr,
                       output logic [31:0] data, output logic valid);
        @(negedge clk);
        ip_data_addr = addr;
        ip_data_rd   = rd;
        ip_data_wr   = wr;
        #1;
        data  = op_data_from_dev;
        valid = op_data_valid;
        @(posedge clk);
        #1;
        ip_data_rd   = 1'b0;
        ip_data_wr   = 1'b0;
        ip_data_addr = 32'h0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        ip_uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ip_uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            ip_uart_rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            ip_uart_rx = 1'b0;
            repeat (12) @(negedge clk);
            ip_uart_rx = 1'b1;
            repeat (CPB - 12) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    // scoreboard helpers: the model keeps at most DEPTH bytes, extra ones drop
    task automatic send_good(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic read_rx(input string nm);
        logic [31:0] d;
        logic        v;
        logic [31:0] exp;
        exp = 32'h0;
        if (exp_q.size() > 0) exp = {24'b0, exp_q.pop_front()};
        bus(RX_A, 1'b1, 1'b0, d, v);
        check(nm, d, exp);
    endtask

    task automatic check_status(input string nm, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus(ST_A, 1'b0, 1'b0, d, v);
        check(nm, d, exp);
        check({nm, "_irq"}, 32'(op_rx_irq), 32'(exp[ST_NOT_EMPTY]));
    endtask

    task automatic clear_flags();
        logic [31:0] d;
        logic        v;
        bus(ST_A, 1'b0, 1'b1, d, v);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        int          n;

        total = 0;
        bad   = 0;
        vecs[0] = '{32'h54,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{ST_A,    1'b0, 1'b0, 1'b1, 32'h1};
        vecs[2] = '{RX_A,    1'b0, 1'b0, 1'b1, 32'h41};
        vecs[3] = '{32'h60,  1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{RX_A,    1'b0, 1'b1, 1'b1, 32'h41};
        vecs[5] = '{32'h59,  1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{ST_A,    1'b0, 1'b0, 1'b1, 32'h1};
        vecs[7] = '{RX_A,    1'b1, 1'b0, 1'b1, 32'h41};
        vecs[8] = '{ST_A,    1'b0, 1'b0, 1'b1, 32'h0};
        vecs[9] = '{RX_A,    1'b0, 1'b0, 1'b1, 32'h0};

        reset        = 1'b1;
        ip_uart_rx   = 1'b1;
        ip_data_addr = 32'h0;
        ip_data_rd   = 1'b0;
        ip_data_wr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(op_data_valid), 32'h0);
        check("rst_data", op_data_from_dev, 32'h0);
        check("rst_irq", 32'(op_rx_irq), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dut.u_deser.state), 32'(RX_IDLE));
        check_status("rst_status", 32'h0);

        // single byte with visibility latency, then the decode table
        @(negedge clk);
        n = 0;
        fork
            send_frame(8'h41, 1'b1);
            begin
                while (!op_rx_irq && n < 400) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("latency_ok", 32'(n <= 2 + CPB * 19 / 2 + 2), 32'h1);
        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].addr, vecs[i].rd, vecs[i].wr, d, v);
            check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
        end
        check("after_pop_irq", 32'(op_rx_irq), 32'h0);

        // short low glitch must be rejected
        @(negedge clk);
        ip_uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        ip_uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_state", 32'(dut.u_deser.state), 32'(RX_IDLE));
        check_status("glitch_status", 32'h0);
        @(negedge clk);
        send_good(8'h7E);
        read_rx("rx_7e");

        // framing error, then software clear
        @(negedge clk);
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check_status("frame_err_status", 32'h4);
        clear_flags();
        check_status("frame_clr_status", 32'h0);

        // overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            send_good(8'(i));
        end
        check_status("overrun_status", 32'h3);
        for (int i = 0; i < 4; i++) read_rx($sformatf("ovr_rd%0d", i));
        check_status("overrun_left", 32'h2);
        clear_flags();
        check_status("overrun_clr", 32'h0);

        // pop on the exact edge a fifth byte arrives at a full FIFO
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send_good(8'h10 + 8'(i));
        end
        check_status("full_status", 32'h1);
        @(negedge clk);
        n = 0;
        fork
            send_frame(8'h14, 1'b1);
            begin
                while (!dut.rx_push && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("coinc_found", 32'(n < 400), 32'h1);
                if (n < 400) begin
                    ip_data_addr = RX_A;
                    ip_data_rd   = 1'b1;
                    #1;
                    check("coinc_head", op_data_from_dev, {24'b0, exp_q.pop_front()});
                    @(posedge clk);
                    #1;
                    ip_data_rd   = 1'b0;
                    ip_data_addr = 32'h0;
                end
            end
        join
        exp_q.push_back(8'h14);
        check_status("coinc_status", 32'h1);
        for (int i = 0; i < 4; i++) read_rx($sformatf("coinc_rd%0d", i));
        check_status("coinc_empty", 32'h0);

        // reset during bit 3 of 0xA5 discards the partial byte
        @(negedge clk);
        ip_uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ip_uart_rx = logic'((8'hA5 >> i) & 8'h1);
            repeat (CPB) @(negedge clk);
        end
        ip_uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        ip_uart_rx = 1'b1;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check("mid_rst_state", 32'(dut.u_deser.state), 32'(RX_IDLE));
        check_status("mid_rst_status", 32'h0);
        @(negedge clk);
        send_good(8'h3C);
        read_rx("rx_3c");
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Receive side of the SoC UART: 8N1 serial deserializer, small receive FIFO, and a memory-mapped read/status port on the processor data bus.
- Sits beside dmem; the SoC steers data accesses to RX_DATA_LOC and STATUS_LOC here.
- Supplies the real device status that the UART MMIO read path needs, replacing the hard-wired constant.
- The TX write location UART_IO_MM_LOC (0x54) is not decoded here.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); minimum 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- RX_DATA_LOC, 32'h00000058, byte address of the RX data register (read pops the FIFO).
- STATUS_LOC, 32'h0000005C, byte address of the status register (write clears the sticky flags).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ip_uart_rx  in  1  asynchronous serial input; idle high
- ip_data_addr  in  32  processor data address
- ip_data_rd  in  1  load strobe, one cycle per load
- ip_data_wr  in  1  store strobe
- op_data_valid  out  1  high when this block is responding to the current address
- op_data_from_dev  out  32  read data
- op_rx_irq  out  1  high while the FIFO is not empty

Behaviour:
- Reset: one clock, reset is synchronous and active-high.
  - Synchronizer flops are set to 1.
  - FSM goes to IDLE; bit counter and cycle counter are cleared.
  - FIFO is emptied; overrun and frame_err are cleared.
  - op_data_valid=0, op_data_from_dev=0, op_rx_irq=0.
  - Reset mid-frame discards the partial byte; reception resumes on the next falling edge after reset deasserts.
- Input synchronization: 2-flop synchronizer on ip_uart_rx. The FSM sees only the synchronized value, rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s=0, go to START and set cnt=0.
  - START: at cnt=CLKS_PER_BIT/2-1, sample rx_s.
    - If 0: go to DATA, clear cnt and the bit index.
    - If 1: treat as a glitch and return to IDLE.
  - DATA: at cnt=CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and clear cnt. After bit 7, go to STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
    - If 1: issue a one-cycle push of the byte.
    - If 0: set frame_err and discard the byte.
    - Either way, return to IDLE.
  - No break detection. A line held low after a framing error simply begins a new START check.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits, plus a count of $clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push when full: byte dropped, overrun set, FIFO unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. When full, the push is accepted and no overrun is flagged.
  - Pop when empty: no state change.
- Byte-visibility latency: a pushed byte is visible (status bit0=1, op_rx_irq=1) on the cycle after the stop-bit sample edge.
- MMIO read (combinational):
  - addr==RX_DATA_LOC: op_data_valid=1, op_data_from_dev={24'b0, head byte}, or 0 if empty. If ip_data_rd=1, pop at the clock edge.
  - addr==STATUS_LOC: op_data_valid=1, op_data_from_dev={29'b0, frame_err, overrun, not_empty}.
  - Any other address: op_data_valid=0, op_data_from_dev=0.
- MMIO write:
  - ip_data_wr with addr==STATUS_LOC clears overrun and frame_err at the clock edge, whatever the write data.
  - If a set event occurs in the same cycle as the clear, the set wins.
  - Writes to RX_DATA_LOC are ignored.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (2 bits).
  - Status bit indices: ST_NOT_EMPTY=0, ST_OVERRUN=1, ST_FRAME_ERR=2.
  - Default RX_DATA_LOC and STATUS_LOC next to UART_IO_MM_LOC.
- Sub-module uart_rx_deser:
  - Contains the synchronizer and FSM.
  - Outputs: byte[7:0], byte_valid pulse, frame_err_pulse.
- The FIFO and MMIO decode stay in uart_rx_mmio.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0x41 -> within 2+16*9.5+2 cycles status reads 0x1 and op_rx_irq=1; RX_DATA read returns 0x00000041; status then reads 0x0 and op_rx_irq=0.
- Pull rx low for 4 cycles, then high -> no push; FSM back in IDLE; status 0x0; a following 0x7E is received correctly.
- Send 0x55 with stop bit 0 -> status 0x4 and FIFO empty; write STATUS_LOC -> status 0x0.
- Send 0x01..0x05 with no reads -> status 0x3; four RX_DATA reads return 1, 2, 3, 4; status then 0x2.
- Fill the FIFO with 0x10..0x13, then pop on the exact cycle 0x14 is pushed -> read returns 0x10; no overrun; subsequent reads return 0x11, 0x12, 0x13, 0x14.
- Assert reset for one cycle during bit 3 of 0xA5 -> status 0x0 and no byte pushed; the next frame 0x3C reads back 0x0000003C.
